// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8N1 UART transmitter with a one-entry holding register.
//
// Bytes are accepted on a valid/ready handshake and serialised LSB first as
// one start bit (0), eight data bits and one stop bit (1). A byte offered
// while a frame is on the line is parked in the holding register and follows
// the current frame with no idle gap.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUD_RATE  serial bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   tx_data    in   byte to send, sampled in the accept cycle only
//   tx_valid   in   producer has a byte on tx_data
//   tx_ready   out  block can accept (holding register empty)
//   tx_serial  out  registered serial line, idle high
//   tx_busy    out  high while a frame is on the line
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // 3-bit encoding leaves spare codes; those fall into the default branch.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic             r_tx_serial;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_bit_next;
    logic [7:0]       w_shift_next;
    logic [7:0]       w_hold_next;
    logic             w_hold_full_next;
    logic             w_serial_next;
    logic             w_accept;
    logic             w_bit_done;

    // Ready depends only on the holding flag, so there is no path from tx_valid.
    assign w_accept   = tx_valid && !r_hold_full;
    assign w_bit_done = (r_cnt == '0);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx_serial <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_hold      <= w_hold_next;
            r_hold_full <= w_hold_full_next;
            r_tx_serial <= w_serial_next;
        end
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_bit_next       = r_bit_idx;
        w_shift_next     = r_shift;
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;

        case (r_state)
            IDLE: begin
                // Holding register is always empty here; load straight into the shifter.
                if (w_accept) begin
                    w_state_next = START;
                    w_cnt_next   = CNT_RELOAD;
                    w_shift_next = tx_data;
                end
            end

            START: begin
                if (w_accept) begin
                    w_hold_next      = tx_data;
                    w_hold_full_next = 1'b1;
                end
                if (w_bit_done) begin
                    w_state_next = DATA;
                    w_cnt_next   = CNT_RELOAD;
                    w_bit_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end

            DATA: begin
                if (w_accept) begin
                    w_hold_next      = tx_data;
                    w_hold_full_next = 1'b1;
                end
                if (w_bit_done) begin
                    w_cnt_next = CNT_RELOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end

            STOP: begin
                if (w_bit_done) begin
                    // Chain the next frame without an idle cycle when a byte is available.
                    if (r_hold_full) begin
                        w_state_next     = START;
                        w_cnt_next       = CNT_RELOAD;
                        w_shift_next     = r_hold;
                        w_hold_full_next = 1'b0;
                    end else if (w_accept) begin
                        w_state_next = START;
                        w_cnt_next   = CNT_RELOAD;
                        w_shift_next = tx_data;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                    if (w_accept) begin
                        w_hold_next      = tx_data;
                        w_hold_full_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next     = IDLE;
                w_cnt_next       = '0;
                w_bit_next       = '0;
                w_hold_full_next = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------- output logic
    // The line value is computed from the next state so the registered pin
    // changes on the same edge the state does.
    always_comb begin
        w_serial_next = 1'b1;
        case (w_state_next)
            START:   w_serial_next = 1'b0;
            DATA:    w_serial_next = w_shift_next[w_bit_next];
            default: w_serial_next = 1'b1;
        endcase
        tx_ready = !r_hold_full;
        tx_busy  = (r_state != IDLE);
    end

    assign tx_serial = r_tx_serial;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : directed self-checking bench for uart_tx (CLKS_PER_BIT = 10).
// A line monitor on the falling clock edge decodes frames from tx_serial,
// checks every bit is stable for 10 cycles with a valid start/stop, and
// records each byte with the cycle its start bit appeared.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] rx_q  [$];
    int         st_q  [$];
    bit         bad_q [$];

    logic [7:0] vec [5] = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h3C};

    uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Behavioural receiver sampling every cycle on the falling edge.
    initial begin
        bit         in_frame;
        bit         bad;
        logic       cur;
        logic [7:0] sh;
        int         fcnt;
        int         fstart;
        int         bitn;
        int         pos;
        in_frame = 1'b0;
        bad = 1'b0; cur = 1'b1; sh = '0; fcnt = 0; fstart = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tx_serial === 1'b0) begin
                    in_frame = 1'b1;
                    fcnt = 0; fstart = cyc; sh = '0; bad = 1'b0;
                end
                if (in_frame) begin
                    bitn = fcnt / 10;
                    pos  = fcnt % 10;
                    if (pos == 0) cur = tx_serial;
                    else if (tx_serial !== cur) bad = 1'b1;
                    if (pos == 0 && bitn >= 1 && bitn <= 8) sh[bitn-1] = tx_serial;
                    if (bitn == 0 && tx_serial !== 1'b0) bad = 1'b1;
                    if (bitn == 9 && tx_serial !== 1'b1) bad = 1'b1;
                    fcnt++;
                    if (fcnt == 100) begin
                        rx_q.push_back(sh);
                        st_q.push_back(fstart);
                        bad_q.push_back(bad);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_frame(input string tag, input logic [7:0] b, output int st);
        st = -1;
        chk({tag, "_present"}, 32'(rx_q.size() != 0), 32'd1);
        if (rx_q.size() != 0) begin
            chk({tag, "_byte"}, 32'(rx_q.pop_front()), 32'(b));
            chk({tag, "_clean"}, 32'(bad_q.pop_front()), 32'd0);
            st = st_q.pop_front();
        end
    endtask

    initial begin
        int acc, lows, bcnt, rise, st0, st1, st2, idx;
        logic [9:0] pat;
        bit w;

        rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0;

        // 1. reset and idle line
        repeat (3) step();
        chk("rst_serial", 32'(tx_serial), 32'd1);
        chk("rst_ready",  32'(tx_ready),  32'd1);
        chk("rst_busy",   32'(tx_busy),   32'd0);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tx_serial !== 1'b1) lows++;
        end
        chk("idle_high", 32'(lows), 32'd0);

        // 2. single 0xA5 from idle
        tx_data = 8'hA5; tx_valid = 1'b1;
        step();
        acc = cyc;
        tx_valid = 1'b0;
        chk("a5_latency", 32'(tx_serial), 32'd0);
        chk("a5_ready",   32'(tx_ready),  32'd1);
        bcnt = 0; pat = '0;
        for (int i = 0; i < 120; i++) begin
            if (i % 10 == 5 && i < 100) pat[i/10] = tx_serial;
            if (tx_busy) bcnt++;
            step();
        end
        chk("a5_pattern", 32'(pat), 32'h34A);
        chk("a5_busy",    32'(bcnt), 32'd100);
        pop_frame("a5", 8'hA5, st0);
        chk("a5_start", 32'(st0), 32'(acc));

        // 3. 0x00 then 0xFF offered 20 cycles into the first frame
        tx_data = 8'h00; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        bcnt = 0; rise = -1;
        for (int i = 0; i < 230; i++) begin
            if (i == 20) begin
                chk("b2b_ready_pre", 32'(tx_ready), 32'd1);
                tx_data = 8'hFF; tx_valid = 1'b1;
            end
            if (i == 21) begin
                tx_valid = 1'b0;
                chk("b2b_ready_drop", 32'(tx_ready), 32'd0);
            end
            if (i > 21 && rise < 0 && tx_ready) rise = i;
            if (tx_busy) bcnt++;
            step();
        end
        chk("b2b_ready_rise", 32'(rise), 32'd100);
        chk("b2b_busy", 32'(bcnt), 32'd200);
        pop_frame("b2b0", 8'h00, st0);
        pop_frame("b2b1", 8'hFF, st1);
        chk("b2b_contig", 32'(st1 - st0), 32'd100);

        // 4. tx_valid held high across three bytes
        tx_data = 8'h11; tx_valid = 1'b1;
        step();
        tx_data = 8'h22;
        bcnt = 0; rise = -1;
        for (int i = 0; i < 330; i++) begin
            if (i == 1) begin
                chk("hold3_ready1", 32'(tx_ready), 32'd0);
                tx_data = 8'h33;
            end
            if (i == 50) chk("hold3_stall", 32'(tx_ready), 32'd0);
            if (rise >= 0 && i == rise + 1) tx_valid = 1'b0;
            if (i > 1 && rise < 0 && tx_ready) rise = i;
            if (tx_busy) bcnt++;
            step();
        end
        tx_valid = 1'b0;
        chk("hold3_rise", 32'(rise), 32'd100);
        chk("hold3_busy", 32'(bcnt), 32'd300);
        pop_frame("hold3_0", 8'h11, st0);
        pop_frame("hold3_1", 8'h22, st1);
        pop_frame("hold3_2", 8'h33, st2);
        chk("hold3_contig01", 32'(st1 - st0), 32'd100);
        chk("hold3_contig12", 32'(st2 - st1), 32'd100);

        // 5. reset mid-frame with the holding register full
        tx_data = 8'h81; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 35; i++) begin
            if (i == 5) begin tx_data = 8'h99; tx_valid = 1'b1; end
            if (i == 6) tx_valid = 1'b0;
            if (i == 34) rst_n = 1'b0;
            step();
        end
        chk("rst_mid_serial", 32'(tx_serial), 32'd1);
        chk("rst_mid_busy",   32'(tx_busy),   32'd0);
        chk("rst_mid_ready",  32'(tx_ready),  32'd1);
        step();
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (tx_serial !== 1'b1) lows++;
        end
        chk("rst_mid_no_held", 32'(lows), 32'd0);
        chk("rst_mid_no_frame", 32'(rx_q.size()), 32'd0);
        tx_data = 8'h3C; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (110) step();
        pop_frame("rst_clean", 8'h3C, st0);

        // 6. five bytes back-to-back through the line receiver
        idx = 0;
        tx_data = vec[0]; tx_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            w = tx_valid && tx_ready;
            step();
            if (w) begin
                idx++;
                if (idx < 5) tx_data = vec[idx];
                else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        chk("loop_accepts", 32'(idx), 32'd5);
        chk("loop_count", 32'(rx_q.size()), 32'd5);
        st1 = -1;
        for (int k = 0; k < 5; k++) begin
            pop_frame($sformatf("loop%0d", k), vec[k], st0);
            if (k > 0) chk($sformatf("loop_contig%0d", k), 32'(st0 - st1), 32'd100);
            st1 = st0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
